// File: rtl/uart_pkt_ctrl.sv
// Packet controller behind the UART byte receiver: parity check, frame parse
// (A5, LEN, payload, CSUM), speculative payload FIFO with commit/rollback, output stream.
module uart_pkt_ctrl #(
    parameter int PARITY_ODD = 0,
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_parity,
    output logic       pkt_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_last,
    input  logic       pkt_ready,
    output logic       pkt_done,
    output logic       err_parity,
    output logic       err_len,
    output logic       err_csum,
    output logic       err_ovf,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;

    state_t      state, state_n;
    logic [AW:0] wptr_t, wptr_t_n;
    logic [AW:0] wptr_c, wptr_c_n;
    logic [AW:0] rptr, rptr_n;
    logic [7:0]  len, len_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  sum, sum_n;
    logic        done_n, par_n, len_err_n, csum_n, ovf_n;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [8:0]  head;
    logic        wr_en;
    logic [8:0]  wr_word;
    logic [AW:0] occ;
    logic [7:0]  sum_add;
    logic        parity_ok;
    logic        xfer;

    assign parity_ok = ((^rx_data) ^ 1'(PARITY_ODD)) == rx_parity;
    // Occupancy counts committed and tentative entries against the pre-read rptr.
    assign occ       = wptr_t - rptr;
    assign sum_add   = sum + rx_data;
    assign head      = mem[rptr[AW-1:0]];
    assign pkt_valid = (wptr_c != rptr);
    assign pkt_data  = pkt_valid ? head[7:0] : '0;
    assign pkt_last  = pkt_valid ? head[8] : 1'b0;
    assign busy      = (state != IDLE);
    assign xfer      = pkt_valid && pkt_ready;
    assign rptr_n    = rptr + {{AW{1'b0}}, xfer};

    always_comb begin
        state_n   = state;
        wptr_t_n  = wptr_t;
        wptr_c_n  = wptr_c;
        len_n     = len;
        cnt_n     = cnt;
        sum_n     = sum;
        done_n    = 1'b0;
        par_n     = 1'b0;
        len_err_n = 1'b0;
        csum_n    = 1'b0;
        ovf_n     = 1'b0;
        wr_en     = 1'b0;
        wr_word   = {(cnt == 8'(len - 8'd1)), rx_data};
        if (rx_valid) begin
            if (!parity_ok) begin
                par_n    = 1'b1;
                wptr_t_n = wptr_c;
                state_n  = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_data == 8'hA5) state_n = LEN;
                    end
                    LEN: begin
                        if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
                            len_n   = rx_data;
                            sum_n   = rx_data;
                            cnt_n   = '0;
                            state_n = PAYLOAD;
                        end else begin
                            len_err_n = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                    PAYLOAD: begin
                        if (occ == (AW+1)'(FIFO_DEPTH)) begin
                            ovf_n    = 1'b1;
                            wptr_t_n = wptr_c;
                            state_n  = IDLE;
                        end else begin
                            wr_en    = 1'b1;
                            wptr_t_n = wptr_t + 1'b1;
                            cnt_n    = cnt + 8'd1;
                            sum_n    = sum_add;
                            if (cnt == 8'(len - 8'd1)) state_n = CSUM;
                        end
                    end
                    CSUM: begin
                        if (sum_add == 8'd0) begin
                            wptr_c_n = wptr_t;
                            done_n   = 1'b1;
                        end else begin
                            wptr_t_n = wptr_c;
                            csum_n   = 1'b1;
                        end
                        state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wptr_t     <= '0;
            wptr_c     <= '0;
            rptr       <= '0;
            len        <= '0;
            cnt        <= '0;
            sum        <= '0;
            pkt_done   <= 1'b0;
            err_parity <= 1'b0;
            err_len    <= 1'b0;
            err_csum   <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state      <= state_n;
            wptr_t     <= wptr_t_n;
            wptr_c     <= wptr_c_n;
            rptr       <= rptr_n;
            len        <= len_n;
            cnt        <= cnt_n;
            sum        <= sum_n;
            pkt_done   <= done_n;
            err_parity <= par_n;
            err_len    <= len_err_n;
            err_csum   <= csum_n;
            err_ovf    <= ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_t[AW-1:0]] <= wr_word;
    end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Bench for uart_pkt_ctrl: vector table plus frame sequences on a default instance
// and a 4-entry FIFO instance; output stream checked against a scoreboard queue.
module tb_uart_pkt_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0, rx_valid = 1'b0, rx_parity = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rxv_a, rxv_b;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic       a_valid, a_last, a_done, a_par, a_len, a_csum, a_ovf, a_busy;
    logic       b_valid, b_last, b_done, b_par, b_len, b_csum, b_ovf, b_busy;
    logic [7:0] a_data, b_data;

    assign rxv_a = rx_valid & ~sel;
    assign rxv_b = rx_valid & sel;

    uart_pkt_ctrl dut_a (
        .clk(clk), .rst(rst), .rx_valid(rxv_a), .rx_data(rx_data), .rx_parity(rx_parity),
        .pkt_valid(a_valid), .pkt_data(a_data), .pkt_last(a_last), .pkt_ready(ready_a),
        .pkt_done(a_done), .err_parity(a_par), .err_len(a_len), .err_csum(a_csum),
        .err_ovf(a_ovf), .busy(a_busy)
    );

    uart_pkt_ctrl #(.FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rxv_b), .rx_data(rx_data), .rx_parity(rx_parity),
        .pkt_valid(b_valid), .pkt_data(b_data), .pkt_last(b_last), .pkt_ready(ready_b),
        .pkt_done(b_done), .err_parity(b_par), .err_len(b_len), .err_csum(b_csum),
        .err_ovf(b_ovf), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_mode = 1'b0;
    logic [8:0] qa [$];
    logic [8:0] qb [$];

    // Flag vector layout: {busy, done, err_parity, err_len, err_csum, err_ovf}
    typedef logic [5:0] flags_t;
    localparam flags_t NONE = 6'b000000, BUSY = 6'b100000, DONE = 6'b010000,
                       PAR = 6'b001000, LENE = 6'b000100, CSE = 6'b000010, OVF = 6'b000001;

    typedef struct {
        logic [7:0] b;
        bit         flip;
        flags_t     exp;
        bit         push;
        bit         last;
        bit         chk_v;
        bit         ev;
        string      name;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input bit flip, input flags_t e,
                                input bit push, input bit last, input bit chk_v,
                                input bit ev, input string name);
        vec_t v;
        v.b = b; v.flip = flip; v.exp = e; v.push = push; v.last = last;
        v.chk_v = chk_v; v.ev = ev; v.name = name;
        return v;
    endfunction

    function automatic flags_t flags(input bit which);
        if (which) return {b_busy, b_done, b_par, b_len, b_csum, b_ovf};
        return {a_busy, a_done, a_par, a_len, a_csum, a_ovf};
    endfunction

    task automatic send(input bit which, input logic [7:0] b, input bit flip, output flags_t f);
        @(negedge clk);
        sel       = which;
        rx_data   = b;
        rx_parity = (^b) ^ flip;
        rx_valid  = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        f = flags(which);
    endtask

    task automatic send_good(input bit which, input string name, input logic [7:0] p [$]);
        flags_t     f;
        logic [7:0] s;
        send(which, 8'hA5, 1'b0, f);
        check({name, "_hdr"}, 32'(f), 32'(BUSY));
        s = 8'(p.size());
        send(which, s, 1'b0, f);
        check({name, "_len"}, 32'(f), 32'(BUSY));
        foreach (p[i]) begin
            if (which) qb.push_back({i == p.size() - 1, p[i]});
            else       qa.push_back({i == p.size() - 1, p[i]});
            s = s + p[i];
            send(which, p[i], 1'b0, f);
            check({name, "_pay"}, 32'(f), 32'(BUSY));
        end
        send(which, 8'h00 - s, 1'b0, f);
        check({name, "_csum"}, 32'(f), 32'(DONE));
        check({name, "_valid_at_done"}, 32'(which ? b_valid : a_valid), 32'd1);
    endtask

    task automatic wait_drain(input bit which, input string name);
        for (int i = 0; i < 600; i++) begin
            if ((which ? qb.size() : qa.size()) == 0) break;
            @(negedge clk);
        end
        check({name, "_drained"}, 32'(which ? qb.size() : qa.size()), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_idle"}, 32'(which ? b_valid : a_valid), 32'd0);
    endtask

    // Output monitors: stalled data must hold; each transfer pops the scoreboard.
    bit         stall_a = 1'b0, stall_b = 1'b0;
    logic [8:0] held_a, held_b;

    always @(negedge clk) begin
        if (rst) stall_a = 1'b0;
        else begin
            if (stall_a) begin
                check("a_stall_valid", 32'(a_valid), 32'd1);
                check("a_stall_data", 32'({a_last, a_data}), 32'(held_a));
            end
            if (a_valid && ready_a) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_out: got 0x%0h, expected no output", {a_last, a_data});
                end else check("a_out", 32'({a_last, a_data}), 32'(qa.pop_front()));
            end
            stall_a = a_valid && !ready_a;
            held_a  = {a_last, a_data};
        end
    end

    always @(negedge clk) begin
        if (rst) stall_b = 1'b0;
        else begin
            if (stall_b) begin
                check("b_stall_valid", 32'(b_valid), 32'd1);
                check("b_stall_data", 32'({b_last, b_data}), 32'(held_b));
            end
            if (b_valid && ready_b) begin
                if (qb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_out: got 0x%0h, expected no output", {b_last, b_data});
                end else check("b_out", 32'({b_last, b_data}), 32'(qb.pop_front()));
            end
            stall_b = b_valid && !ready_b;
            held_b  = {b_last, b_data};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_mode) ready_a = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        flags_t     f;
        logic [7:0] p [$];

        // good, bad csum, good, parity abort, idle parity, good, len errors, good
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "g1_hdr"));
        vecs.push_back(mk(8'h03, 0, BUSY, 0, 0, 0, 0, "g1_len"));
        vecs.push_back(mk(8'h11, 0, BUSY, 1, 0, 0, 0, "g1_p0"));
        vecs.push_back(mk(8'h22, 0, BUSY, 1, 0, 0, 0, "g1_p1"));
        vecs.push_back(mk(8'h33, 0, BUSY, 1, 1, 0, 0, "g1_p2"));
        vecs.push_back(mk(8'h97, 0, DONE, 0, 0, 1, 1, "g1_csum"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "bc_hdr"));
        vecs.push_back(mk(8'h03, 0, BUSY, 0, 0, 0, 0, "bc_len"));
        vecs.push_back(mk(8'h11, 0, BUSY, 0, 0, 0, 0, "bc_p0"));
        vecs.push_back(mk(8'h22, 0, BUSY, 0, 0, 0, 0, "bc_p1"));
        vecs.push_back(mk(8'h33, 0, BUSY, 0, 0, 0, 0, "bc_p2"));
        vecs.push_back(mk(8'h98, 0, CSE,  0, 0, 1, 0, "bc_csum"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "g2_hdr"));
        vecs.push_back(mk(8'h02, 0, BUSY, 0, 0, 0, 0, "g2_len"));
        vecs.push_back(mk(8'h55, 0, BUSY, 1, 0, 0, 0, "g2_p0"));
        vecs.push_back(mk(8'h66, 0, BUSY, 1, 1, 0, 0, "g2_p1"));
        vecs.push_back(mk(8'h43, 0, DONE, 0, 0, 1, 1, "g2_csum"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "pe_hdr"));
        vecs.push_back(mk(8'h03, 0, BUSY, 0, 0, 0, 0, "pe_len"));
        vecs.push_back(mk(8'h11, 0, BUSY, 0, 0, 0, 0, "pe_p0"));
        vecs.push_back(mk(8'h22, 1, PAR,  0, 0, 0, 0, "pe_bad"));
        vecs.push_back(mk(8'h33, 0, NONE, 0, 0, 0, 0, "pe_tail0"));
        vecs.push_back(mk(8'h97, 0, NONE, 0, 0, 1, 0, "pe_tail1"));
        vecs.push_back(mk(8'h3C, 1, PAR,  0, 0, 0, 0, "pe_idle"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "g3_hdr"));
        vecs.push_back(mk(8'h01, 0, BUSY, 0, 0, 0, 0, "g3_len"));
        vecs.push_back(mk(8'h7E, 0, BUSY, 1, 1, 0, 0, "g3_p0"));
        vecs.push_back(mk(8'h81, 0, DONE, 0, 0, 1, 1, "g3_csum"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "l0_hdr"));
        vecs.push_back(mk(8'h00, 0, LENE, 0, 0, 0, 0, "l0_len"));
        vecs.push_back(mk(8'h11, 0, NONE, 0, 0, 0, 0, "l0_tail"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "l17_hdr"));
        vecs.push_back(mk(8'h11, 0, LENE, 0, 0, 0, 0, "l17_len"));
        vecs.push_back(mk(8'h05, 0, NONE, 0, 0, 0, 0, "l17_tail"));
        vecs.push_back(mk(8'hA5, 0, BUSY, 0, 0, 0, 0, "g4_hdr"));
        vecs.push_back(mk(8'h01, 0, BUSY, 0, 0, 0, 0, "g4_len"));
        vecs.push_back(mk(8'h10, 0, BUSY, 1, 1, 0, 0, "g4_p0"));
        vecs.push_back(mk(8'hEF, 0, DONE, 0, 0, 1, 1, "g4_csum"));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_outs", 32'({a_valid, a_data, a_last, a_done, a_par, a_len, a_csum, a_ovf, a_busy}), 32'd0);
        check("rst_b_outs", 32'({b_valid, b_data, b_last, b_done, b_par, b_len, b_csum, b_ovf, b_busy}), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        ready_a = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].push) qa.push_back({vecs[i].last, vecs[i].b});
            send(1'b0, vecs[i].b, vecs[i].flip, f);
            check(vecs[i].name, 32'(f), 32'(vecs[i].exp));
            if (vecs[i].chk_v) check({vecs[i].name, "_valid"}, 32'(a_valid), 32'(vecs[i].ev));
        end
        wait_drain(1'b0, "table");

        p = {};
        for (int i = 1; i <= 16; i++) p.push_back(8'(i));
        send_good(1'b0, "maxlen", p);
        wait_drain(1'b0, "maxlen");

        rand_mode = 1'b1;
        send_good(1'b0, "bp1", '{8'hA1, 8'hB2, 8'hC3, 8'hD4});
        send_good(1'b0, "bp2", '{8'h5A, 8'h3C});
        send_good(1'b0, "bp3", '{8'h00, 8'hFF, 8'h80});
        wait_drain(1'b0, "bp");
        rand_mode = 1'b0;

        @(posedge clk);
        #2;
        ready_a = 1'b0;
        send_good(1'b0, "pre_rst", '{8'h10});
        send(1'b0, 8'hA5, 1'b0, f);
        send(1'b0, 8'h02, 1'b0, f);
        send(1'b0, 8'h44, 1'b0, f);
        check("mid_payload_busy", 32'(f), 32'(BUSY));
        check("pre_rst_valid", 32'(a_valid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outs", 32'({a_valid, a_data, a_last, a_done, a_par, a_len, a_csum, a_ovf, a_busy}), 32'd0);
        qa.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outs", 32'({a_valid, a_data, a_last, a_done, a_par, a_len, a_csum, a_ovf, a_busy}), 32'd0);
        @(posedge clk);
        #2;
        ready_a = 1'b1;
        send_good(1'b0, "post_rst", '{8'hC0, 8'h0D});
        wait_drain(1'b0, "post_rst");

        send_good(1'b1, "ovf_first", '{8'h01, 8'h02, 8'h03});
        send(1'b1, 8'hA5, 1'b0, f);
        send(1'b1, 8'h02, 1'b0, f);
        send(1'b1, 8'h04, 1'b0, f);
        check("ovf_fill", 32'(f), 32'(BUSY));
        send(1'b1, 8'h05, 1'b0, f);
        check("ovf_err", 32'(f), 32'(OVF));
        check("ovf_valid", 32'(b_valid), 32'd1);
        send(1'b1, 8'hF5, 1'b0, f);
        check("ovf_tail", 32'(f), 32'(NONE));
        @(posedge clk);
        #2;
        ready_b = 1'b1;
        wait_drain(1'b1, "ovf");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
